// File: rtl/mem_unit_param.sv
// mem_unit_param: byte-addressable big-endian memory with MFA/MFC handshake and wait states.
module mem_unit_param #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic                  mfa_i,
    input  logic                  rw_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           data_in_i,
    input  logic [1:0]            size_i,
    output logic [31:0]           data_out_o,
    output logic                  mfc_o,
    output logic                  err_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rw_q;
    logic [1:0]            size_q;
    logic [31:0]           wdata_q;
    logic [7:0]            mem_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] a1, a2, a3;
    logic                  err_w;
    logic                  fire_w;
    logic [31:0]           rdata_w;
    always_comb begin
        a1      = addr_q + ADDR_WIDTH'(1);
        a2      = addr_q + ADDR_WIDTH'(2);
        a3      = addr_q + ADDR_WIDTH'(3);
        err_w   = (size_q == 2'b11) || (size_q == 2'b01 && addr_q[0]) ||
                  (size_q == 2'b10 && addr_q[1:0] != 2'b00);
        rdata_w = size_q == 2'b00 ? {24'h0, mem_q[addr_q]} :
                  size_q == 2'b01 ? {16'h0, mem_q[addr_q], mem_q[a1]} :
                  {mem_q[addr_q], mem_q[a1], mem_q[a2], mem_q[a3]};
        fire_w  = !clr_i && state_q == BUSY && cnt_q == 4'd0;
    end
    // The array has no reset; a write commits only on an error-free completion not pre-empted by clr.
    always_ff @(posedge clk_i) begin
        if (fire_w && !rw_q && !err_w) begin
            if (size_q == 2'b00) begin
                mem_q[addr_q] <= wdata_q[7:0];
            end else if (size_q == 2'b01) begin
                mem_q[addr_q] <= wdata_q[15:8];
                mem_q[a1]     <= wdata_q[7:0];
            end else begin
                mem_q[addr_q] <= wdata_q[31:24];
                mem_q[a1]     <= wdata_q[23:16];
                mem_q[a2]     <= wdata_q[15:8];
                mem_q[a3]     <= wdata_q[7:0];
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            mfc_o      <= 1'b0;
            err_o      <= 1'b0;
            data_out_o <= 32'h0;
        end else begin
            case (state_q)
                IDLE: if (mfa_i) begin
                    addr_q  <= addr_i;
                    rw_q    <= rw_i;
                    size_q  <= size_i;
                    wdata_q <= data_in_i;
                    cnt_q   <= 4'(WAIT_STATES);
                    state_q <= BUSY;
                end
                BUSY: if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    mfc_o   <= 1'b1;
                    err_o   <= err_w;
                    state_q <= DONE;
                    if (err_w) data_out_o <= 32'h0;
                    else if (rw_q) data_out_o <= rdata_w;
                end
                DONE: if (!mfa_i) begin
                    mfc_o   <= 1'b0;
                    err_o   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_unit_param.sv
// tb_mem_unit_param: directed vector checks of two memory instances (2 wait states / 0 wait states).
module tb_mem_unit_param;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        mfa = 1'b0;
    logic        rw = 1'b1;
    logic [9:0]  addr = '0;
    logic [31:0] din = '0;
    logic [1:0]  size = '0;
    logic [31:0] dout_a, dout_b;
    logic        mfc_a, mfc_b, err_a, err_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_unit_param #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_a (
        .clk_i(clk), .clr_i(clr), .mfa_i(mfa), .rw_i(rw), .addr_i(addr[7:0]),
        .data_in_i(din), .size_i(size), .data_out_o(dout_a), .mfc_o(mfc_a), .err_o(err_a));
    mem_unit_param #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
        .clk_i(clk), .clr_i(clr), .mfa_i(mfa), .rw_i(rw), .addr_i(addr),
        .data_in_i(din), .size_i(size), .data_out_o(dout_b), .mfc_o(mfc_b), .err_o(err_b));

    typedef struct {
        logic        rw;
        logic [9:0]  addr;
        logic [1:0]  size;
        logic [31:0] din;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic sel_mfc(input bit b);
        return b ? mfc_b : mfc_a;
    endfunction

    task automatic wait_mfc(input bit b, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!sel_mfc(b) && lat < 40);
    endtask

    task automatic drop_mfa(input bit b);
        @(negedge clk);
        mfa = 1'b0;
        @(posedge clk);
        #1;
        chk("mfc_fall", 32'(sel_mfc(b)), 32'd0);
    endtask

    task automatic access(input bit b, input logic r, input logic [9:0] a, input logic [1:0] sz,
                          input logic [31:0] d, output logic [31:0] q, output logic e, output int lat);
        @(negedge clk);
        mfa = 1'b1; rw = r; addr = a; size = sz; din = d;
        @(posedge clk);
        wait_mfc(b, lat);
        q = b ? dout_b : dout_a;
        e = b ? err_b : err_a;
        drop_mfa(b);
    endtask

    // Inputs are scrambled after acceptance and during a 5-cycle MFA hold; only latched values may matter.
    task automatic hold_seq(input logic r, input logic [9:0] a, input logic [31:0] d, output logic [31:0] q);
        int lat;
        @(negedge clk);
        mfa = 1'b1; rw = r; addr = a; size = 2'b10; din = d;
        @(posedge clk);
        @(negedge clk);
        rw = ~r; addr = a ^ 10'h00C; size = 2'b00; din = ~d;
        wait_mfc(1'b0, lat);
        chk("hold_lat", 32'(lat), 32'd3);
        q = dout_a;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            addr = a ^ 10'h004; din = 32'(i); rw = r;
            @(posedge clk);
            #1;
            chk("hold_mfc", 32'(mfc_a), 32'd1);
            chk("hold_dout", dout_a, q);
        end
        drop_mfa(1'b0);
    endtask

    vec_t        vt[$];
    logic [31:0] q;
    logic        e;
    int          lat;

    initial begin
        vt.push_back('{1'b0, 10'h018, 2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vt.push_back('{1'b0, 10'h020, 2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vt.push_back('{1'b0, 10'h010, 2'b10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
        vt.push_back('{1'b1, 10'h010, 2'b10, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vt.push_back('{1'b1, 10'h010, 2'b00, 32'h0,         32'h0000_00DE, 1'b0});
        vt.push_back('{1'b1, 10'h013, 2'b00, 32'h0,         32'h0000_00EF, 1'b0});
        vt.push_back('{1'b1, 10'h012, 2'b01, 32'h0,         32'h0000_BEEF, 1'b0});
        vt.push_back('{1'b0, 10'h011, 2'b00, 32'h0000_00A5, 32'h0000_BEEF, 1'b0});
        vt.push_back('{1'b0, 10'h012, 2'b01, 32'h0000_1234, 32'h0000_BEEF, 1'b0});
        vt.push_back('{1'b1, 10'h010, 2'b10, 32'h0,         32'hDEA5_1234, 1'b0});
        vt.push_back('{1'b1, 10'h011, 2'b10, 32'h0,         32'h0000_0000, 1'b1});
        vt.push_back('{1'b1, 10'h010, 2'b10, 32'h0,         32'hDEA5_1234, 1'b0});
        vt.push_back('{1'b0, 10'h012, 2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vt.push_back('{1'b1, 10'h010, 2'b10, 32'h0,         32'hDEA5_1234, 1'b0});
        vt.push_back('{1'b1, 10'h013, 2'b01, 32'h0,         32'h0000_0000, 1'b1});
        vt.push_back('{1'b1, 10'h010, 2'b11, 32'h0,         32'h0000_0000, 1'b1});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout_a, 32'h0);
        chk("rst_mfc", 32'(mfc_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        foreach (vt[i]) begin
            access(1'b0, vt[i].rw, vt[i].addr, vt[i].size, vt[i].din, q, e, lat);
            chk($sformatf("vec%0d_data", i), q, vt[i].exp_data);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
        end

        hold_seq(1'b0, 10'h014, 32'hCAFE_F00D, q);
        chk("hold_wr_dout", q, 32'h0);
        hold_seq(1'b1, 10'h010, 32'h0, q);
        chk("hold_rd_latched", q, 32'hDEA5_1234);
        access(1'b0, 1'b1, 10'h014, 2'b10, 32'h0, q, e, lat);
        chk("after_hold_data", q, 32'hCAFE_F00D);
        chk("after_hold_lat", 32'(lat), 32'd3);
        access(1'b0, 1'b1, 10'h018, 2'b10, 32'h0, q, e, lat);
        chk("no_stray_write", q, 32'h0);
        access(1'b0, 1'b1, 10'h010, 2'b10, 32'h0, q, e, lat);
        chk("pre_clr_data", q, 32'hDEA5_1234);

        @(negedge clk);
        mfa = 1'b1; rw = 1'b0; addr = 10'h020; size = 2'b10; din = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_dout", dout_a, 32'h0);
        chk("clr_mfc", 32'(mfc_a), 32'd0);
        chk("clr_err", 32'(err_a), 32'd0);
        @(negedge clk);
        clr = 1'b0; mfa = 1'b0;
        access(1'b0, 1'b1, 10'h020, 2'b10, 32'h0, q, e, lat);
        chk("abort_data", q, 32'h0);
        chk("abort_lat", 32'(lat), 32'd3);
        access(1'b0, 1'b1, 10'h010, 2'b10, 32'h0, q, e, lat);
        chk("survive_data", q, 32'hDEA5_1234);

        access(1'b1, 1'b0, 10'h3FC, 2'b10, 32'h89AB_CDEF, q, e, lat);
        chk("ws0_wr_lat", 32'(lat), 32'd1);
        chk("ws0_wr_err", 32'(e), 32'd0);
        access(1'b1, 1'b1, 10'h3FC, 2'b10, 32'h0, q, e, lat);
        chk("ws0_rd_data", q, 32'h89AB_CDEF);
        chk("ws0_rd_lat", 32'(lat), 32'd1);
        access(1'b1, 1'b1, 10'h3FF, 2'b00, 32'h0, q, e, lat);
        chk("ws0_byte_data", q, 32'h0000_00EF);
        chk("ws0_byte_lat", 32'(lat), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
